// File: rtl/cacheline_adaptor_if.sv
// Bus bundle between the cache's physical-memory port, the line/burst adaptor and the burst memory.
// Latency: none; wires only.
// Backpressure: read_i/write_i are held by the cache until resp_o; memory paces beats with resp_i.
// Ports (adaptor view, modport slave):
//   cache side : line_i, address_i, read_i, write_i -> ; line_o, resp_o <-
//   memory side: burst_i, resp_i -> ; burst_o, address_o, read_o, write_o <-
// The master modport is the environment side (cache plus memory model).
interface cacheline_adaptor_if #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
);
    // cache side
    logic [LINE_W-1:0]  line_i;
    logic [LINE_W-1:0]  line_o;
    logic [ADDR_W-1:0]  address_i;
    logic               read_i;
    logic               write_i;
    logic               resp_o;
    // memory side
    logic [BURST_W-1:0] burst_i;
    logic [BURST_W-1:0] burst_o;
    logic [ADDR_W-1:0]  address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts one cacheline read/write into a BEATS-beat burst to memory, then pulses resp_o once.
// Latency: request sampled cycle 0, burst cycles 1..BEATS at the earliest, resp_o in cycle BEATS+1.
// Backpressure: memory stalls the burst by holding resp_i low; the cache holds its request until resp_o.
// Ports: clk, rst (async active-low); bus (slave modport) carries the cache and memory signals.
module cacheline_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cacheline_adaptor_if.slave   bus
);
    localparam int OFFS  = $clog2(LINE_W / 8);
    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   wline_q;
    logic [LINE_W-1:0]   rline_q;
    logic                read_q;
    logic                write_q;
    logic                resp_q;

    // Line-aligned version of the incoming request address.
    logic [ADDR_W-1:0]   addr_aligned;
    assign addr_aligned = {bus.address_i[ADDR_W-1:OFFS], {OFFS{1'b0}}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            // resp_q is a single-cycle pulse; only the final-beat branches raise it.
            resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Write has priority if the cache raises both.
                    if (bus.write_i) begin
                        wline_q <= bus.line_i;
                        addr_q  <= addr_aligned;
                        cnt_q   <= '0;
                        write_q <= 1'b1;
                        state_q <= WR_BURST;
                    end else if (bus.read_i) begin
                        addr_q  <= addr_aligned;
                        cnt_q   <= '0;
                        read_q  <= 1'b1;
                        state_q <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (bus.resp_i) begin
                        rline_q[int'(cnt_q) * BURST_W +: BURST_W] <= bus.burst_i;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BEAT) begin
                            read_q  <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                WR_BURST: begin
                    if (bus.resp_i) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BEAT) begin
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.line_o    = rline_q;
    assign bus.address_o = addr_q;
    assign bus.read_o    = read_q;
    assign bus.write_o   = write_q;
    assign bus.resp_o    = resp_q;
    // Write beat follows the counter directly so the next beat is presented right after each accept.
    assign bus.burst_o   = (state_q == WR_BURST) ? wline_q[int'(cnt_q) * BURST_W +: BURST_W]
                                                 : '0;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, writes, stalls, priority, async reset, back-to-back.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Prints one summary line.
module tb_cacheline_adaptor;
    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int ADDR_W  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cacheline_adaptor_if #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) bus ();

    cacheline_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic rd, input logic wr, input logic rs);
        chk({tag, "_read_o"},  LINE_W'(bus.read_o),  LINE_W'(rd));
        chk({tag, "_write_o"}, LINE_W'(bus.write_o), LINE_W'(wr));
        chk({tag, "_resp_o"},  LINE_W'(bus.resp_o),  LINE_W'(rs));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [63:0] rep(input logic [3:0] n);
        return {16{n}};
    endfunction

    logic [LINE_W-1:0]  l1, l3, l5, l6;
    logic [BURST_W-1:0] wb [4];
    logic               pat [7];
    int                 n_resp, n_rd, n_wr;

    initial begin
        rst           = 1'b0;
        bus.line_i    = '0;
        bus.address_i = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.burst_i   = '0;
        bus.resp_i    = 1'b0;
        #2;
        chk_ctl("rst", 1'b0, 1'b0, 1'b0);
        chk("rst_line_o", bus.line_o, '0);
        chk("rst_addr_o", LINE_W'(bus.address_o), '0);
        chk("rst_burst_o", LINE_W'(bus.burst_o), '0);
        @(negedge clk);
        rst = 1'b1;

        // 1: read with back-to-back beats
        cyc();
        bus.address_i = 32'h1234_5678;
        bus.read_i    = 1'b1;
        mid();
        chk_ctl("t1_c0", 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            bus.resp_i  = 1'b1;
            bus.burst_i = rep(4'(c));
            mid();
            chk_ctl($sformatf("t1_c%0d", c), 1'b1, 1'b0, 1'b0);
            chk("t1_addr_o", LINE_W'(bus.address_o), LINE_W'(32'h1234_5660));
        end
        cyc();
        bus.resp_i  = 1'b0;
        bus.burst_i = '0;
        mid();
        chk_ctl("t1_c5", 1'b0, 1'b0, 1'b1);
        l1 = {rep(4'h4), rep(4'h3), rep(4'h2), rep(4'h1)};
        chk("t1_line_o", bus.line_o, l1);
        bus.read_i = 1'b0;
        cyc();
        mid();
        chk_ctl("t1_c6", 1'b0, 1'b0, 1'b0);

        // 2: write; resp_i high in IDLE must be ignored; request changes mid-burst ignored
        cyc();
        wb[0] = rep(4'hA); wb[1] = rep(4'hB); wb[2] = rep(4'hC); wb[3] = rep(4'hD);
        bus.line_i    = {wb[3], wb[2], wb[1], wb[0]};
        bus.address_i = 32'h0000_0040;
        bus.write_i   = 1'b1;
        bus.resp_i    = 1'b1;
        mid();
        chk_ctl("t2_c0", 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c == 2) begin
                bus.line_i    = '1;
                bus.address_i = 32'hFFFF_FFFF;
            end
            mid();
            chk_ctl($sformatf("t2_c%0d", c), 1'b0, 1'b1, 1'b0);
            chk($sformatf("t2_burst_o_%0d", c - 1), LINE_W'(bus.burst_o), LINE_W'(wb[c-1]));
            chk("t2_addr_o", LINE_W'(bus.address_o), LINE_W'(32'h0000_0040));
        end
        cyc();
        mid();
        chk_ctl("t2_c5", 1'b0, 1'b0, 1'b1);
        chk("t2_line_o_kept", bus.line_o, l1);
        bus.write_i = 1'b0;
        bus.resp_i  = 1'b0;
        cyc();
        mid();
        chk_ctl("t2_c6", 1'b0, 1'b0, 1'b0);

        // 3: stalled read, resp_i pattern 1,0,0,1,0,1,1
        cyc();
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bus.address_i = 32'h8000_003F;
        bus.read_i    = 1'b1;
        mid();
        chk_ctl("t3_c0", 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            cyc();
            bus.resp_i  = pat[c-1];
            bus.burst_i = 64'h5A5A_0000_0000_0000 + 64'(c);
            mid();
            chk_ctl($sformatf("t3_c%0d", c), 1'b1, 1'b0, 1'b0);
            chk("t3_addr_o", LINE_W'(bus.address_o), LINE_W'(32'h8000_0020));
        end
        cyc();
        bus.resp_i = 1'b0;
        mid();
        chk_ctl("t3_c8", 1'b0, 1'b0, 1'b1);
        l3 = {64'h5A5A_0000_0000_0007, 64'h5A5A_0000_0000_0006,
              64'h5A5A_0000_0000_0004, 64'h5A5A_0000_0000_0001};
        chk("t3_line_o", bus.line_o, l3);
        bus.read_i = 1'b0;
        cyc();
        mid();
        chk_ctl("t3_c9", 1'b0, 1'b0, 1'b0);

        // 4: read_i and write_i together -> write wins
        cyc();
        bus.line_i    = {rep(4'h9), rep(4'h8), rep(4'h7), rep(4'h6)};
        bus.address_i = 32'h0000_1000;
        bus.read_i    = 1'b1;
        bus.write_i   = 1'b1;
        bus.resp_i    = 1'b1;
        mid();
        chk_ctl("t4_c0", 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            mid();
            chk_ctl($sformatf("t4_c%0d", c), 1'b0, 1'b1, 1'b0);
            chk($sformatf("t4_burst_o_%0d", c - 1), LINE_W'(bus.burst_o), LINE_W'(rep(4'(5 + c))));
        end
        cyc();
        mid();
        chk_ctl("t4_c5", 1'b0, 1'b0, 1'b1);
        chk("t4_line_o_kept", bus.line_o, l3);
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        bus.resp_i  = 1'b0;
        cyc();
        mid();
        chk_ctl("t4_c6", 1'b0, 1'b0, 1'b0);

        // 5: async reset after two read beats, then a clean read
        cyc();
        bus.address_i = 32'h0000_0100;
        bus.read_i    = 1'b1;
        mid();
        for (int c = 1; c <= 2; c++) begin
            cyc();
            bus.resp_i  = 1'b1;
            bus.burst_i = 64'hBAD0_0000_0000_0000 + 64'(c);
            mid();
            chk_ctl($sformatf("t5_pre_c%0d", c), 1'b1, 1'b0, 1'b0);
        end
        cyc();
        bus.resp_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_ctl("t5_rst", 1'b0, 1'b0, 1'b0);
        chk("t5_rst_line_o", bus.line_o, '0);
        chk("t5_rst_addr_o", LINE_W'(bus.address_o), '0);
        chk("t5_rst_burst_o", LINE_W'(bus.burst_o), '0);
        bus.read_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc();
        bus.address_i = 32'h0000_0200;
        bus.read_i    = 1'b1;
        mid();
        chk_ctl("t5_c0", 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            bus.resp_i  = 1'b1;
            bus.burst_i = 64'hC0DE_0000_0000_0000 + 64'(c);
            mid();
            chk_ctl($sformatf("t5_c%0d", c), 1'b1, 1'b0, 1'b0);
        end
        cyc();
        bus.resp_i = 1'b0;
        mid();
        chk_ctl("t5_c5", 1'b0, 1'b0, 1'b1);
        l5 = {64'hC0DE_0000_0000_0004, 64'hC0DE_0000_0000_0003,
              64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0001};
        chk("t5_line_o", bus.line_o, l5);
        chk("t5_addr_o", LINE_W'(bus.address_o), LINE_W'(32'h0000_0200));
        bus.read_i = 1'b0;
        cyc();
        mid();

        // 6: write then read, cache reacting to resp_o; memory always ready
        cyc();
        n_resp = 0;
        n_rd   = 0;
        n_wr   = 0;
        bus.line_i    = {rep(4'h3), rep(4'h2), rep(4'h1), rep(4'h0)};
        bus.address_i = 32'h0000_0300;
        bus.write_i   = 1'b1;
        bus.resp_i    = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) cyc();
            if (bus.read_o) bus.burst_i = 64'h6000_0000_0000_0000 + 64'(n_rd);
            mid();
            if (bus.read_o) begin
                n_rd++;
                chk("t6_rd_addr_o", LINE_W'(bus.address_o), LINE_W'(32'h0000_0400));
            end
            if (bus.write_o) n_wr++;
            if (bus.resp_o) begin
                n_resp++;
                if (bus.write_i) begin
                    bus.write_i   = 1'b0;
                    bus.read_i    = 1'b1;
                    bus.address_i = 32'h0000_0417;
                end else begin
                    bus.read_i = 1'b0;
                end
            end
        end
        bus.resp_i = 1'b0;
        chk("t6_n_resp", LINE_W'(n_resp), LINE_W'(2));
        chk("t6_n_write", LINE_W'(n_wr), LINE_W'(4));
        chk("t6_n_read", LINE_W'(n_rd), LINE_W'(4));
        l6 = {64'h6000_0000_0000_0003, 64'h6000_0000_0000_0002,
              64'h6000_0000_0000_0001, 64'h6000_0000_0000_0000};
        chk("t6_line_o", bus.line_o, l6);
        chk_ctl("t6_end", 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits between the L1 cache controller's physical-memory port and the burst-based main memory model.
- Converts one 256-bit cacheline read or write request into a 4-beat x 64-bit burst on the memory side.
- Returns a single-cycle response to the cache when the whole line has moved.
- Upstream presents a line-aligned address and holds its request until the response.

Parameters:
LINE_W, 256, cacheline width in bits
BURST_W, 64, memory beat width in bits; BEATS = LINE_W/BURST_W = 4
ADDR_W, 32, address width; low log2(LINE_W/8)=5 bits forced to zero on output

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
line_i  input  LINE_W  write data from cache (pmem_wdata)
line_o  output  LINE_W  assembled read line to cache (pmem_rdata)
address_i  input  ADDR_W  request address from cache (pmem_address)
read_i  input  1  line read request (pmem_read)
write_i  input  1  line write request (pmem_write)
resp_o  output  1  line transfer complete (pmem_resp)
burst_i  input  BURST_W  read beat from memory
burst_o  output  BURST_W  write beat to memory
address_o  output  ADDR_W  burst base address, {address_i[31:5],5'b0}
read_o  output  1  burst read request
write_o  output  1  burst write request
resp_i  input  1  memory beat valid/accepted strobe

Behaviour:
- States: IDLE, RD_BURST, WR_BURST, DONE. A 2-bit beat counter cnt and registers for the latched address, the write line and the read line.
- Reset (rst=0, any state, including mid-burst): state=IDLE, cnt=0, line_o=0, address_o=0, burst_o=0, read_o=0, write_o=0, resp_o=0. Any partially received line is discarded.
- IDLE:
  - write_i=1: latch line_i and address_i (low 5 bits zeroed), cnt=0, go to WR_BURST.
  - Otherwise read_i=1: latch address, cnt=0, go to RD_BURST.
  - Both high: write wins.
  - resp_i is ignored in IDLE.
- RD_BURST:
  - read_o=1 and address_o is stable for the whole state.
  - On each edge with resp_i=1: line_o[cnt*64 +: 64] <= burst_i, cnt++.
  - On the edge capturing beat 3: go to DONE.
  - Beats may be non-consecutive; cycles with resp_i=0 stall with no change.
- WR_BURST:
  - write_o=1 and burst_o = latched_line[cnt*64 +: 64], updated combinationally from cnt.
  - On each edge with resp_i=1: cnt++. On the edge where beat 3 is accepted: go to DONE.
- DONE: resp_o=1 for exactly one cycle; read_o=0 and write_o=0; next state IDLE unconditionally.
- line_o after DONE:
  - Holds its value until the next read's first beat overwrites it.
  - A write never alters line_o.
- Beat order is little-end first: beat 0 = bits [63:0].
- Minimum latency with immediate memory: request sampled cycle 0; read_o/write_o high cycles 1-4; resp_o cycle 5.
- Upstream request changes while busy (read_i/write_i/address_i/line_i) are ignored. Only the values latched in IDLE are used.
- In IDLE, a request still held high in the cycle after DONE starts a new transfer. The cache drops its request on resp_o, so this does not occur in normal operation.
- cnt wraps 3->0 on the final beat.
- resp_i in DONE is ignored.

Test Plan:
1. Read, back-to-back beats: address_i=0x1234_5678, read_i=1, memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on cycles 1-4. Required: address_o=0x1234_5660; read_o high cycles 1-4; resp_o=1 only in cycle 5; line_o={0x44..,0x33..,0x22..,0x11..}.
2. Write: line_i={0xDDDD..,0xCCCC..,0xBBBB..,0xAAAA..}, address_i=0x0000_0040, resp_i high every cycle. Required: burst_o sequence AAAA.., BBBB.., CCCC.., DDDD..; write_o high for 4 cycles; resp_o one cycle; line_o unchanged.
3. Stalled read: resp_i pattern 1,0,0,1,0,1,1. Required: beats captured only on resp_i=1 edges; resp_o the cycle after the 4th beat; read_o never drops early.
4. Simultaneous read_i=write_i=1 in IDLE. Required: write burst performed; read_o stays 0.
5. Reset mid-burst: assert rst=0 after 2 read beats, asynchronously between edges. Required: all outputs 0 immediately. A fresh read after release returns a correct full line with no stale beats counted.
6. Back-to-back: write followed by read, with the cache deasserting on resp_o. Required: exactly one resp_o per transfer; the read starts from IDLE with cnt=0; address_o updates to the new read address.
